det3x3_seq_ctrl: RTL and testbench
==================================

Name: det3x3_seq_ctrl

Overview:
- Sequencer that computes the determinant of a signed 8-bit 3x3 matrix by cofactor expansion along row 1.
- It time-shares one external combinational 2x2 determinant datapath.
- Per operation it presents three 2x2 minors in turn, captures each minor determinant with its overflow flag, then multiplies, accumulates and reports an 8-bit result plus an overflow flag.
- Sits between the coprocessor instruction decoder (start/done handshake) and the shared 2x2 determinant unit.

Parameters:
- ACC_W, 18, accumulator width in bits; must be at least 18 so a 3-term sum of 16-bit products cannot wrap.
- SAT, 0, output mode: 0 truncates the result to 8 bits; 1 saturates to +127/-128 on overflow.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only while idle.
- matriz_3x3  input  72  nine signed 8-bit elements, row-major. a11=[71:64], a12=[63:56], a13=[55:48], a21=[47:40], a22=[39:32], a23=[31:24], a31=[23:16], a32=[15:8], a33=[7:0].
- minor_out  output  32  packed minor to the 2x2 unit: [31:24]=m11, [23:16]=m12, [15:8]=m21, [7:0]=m22.
- minor_det_in  input  8  signed determinant returned by the 2x2 unit, combinational from minor_out.
- minor_ovf_in  input  1  overflow flag returned by the 2x2 unit.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when det/overflow_flag are valid.
- det  output  8  signed 3x3 determinant (truncated or saturated per SAT).
- overflow_flag  output  1  true result is outside [-128,127], or any minor overflowed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; busy=0, done=0, det=0, overflow_flag=0, minor_out=0.
  - Accumulator, latched matrix and sticky minor-overflow are cleared.
- States: IDLE -> M0 -> M1 -> M2 -> FIN -> IDLE.
- IDLE: if start=1 at the edge, latch matriz_3x3, clear accumulator and sticky overflow, go to M0, busy<=1. Otherwise hold. done is high only in the first IDLE cycle after FIN.
- M0:
  - minor_out = {a22,a23,a32,a33}.
  - At the edge: acc += a11*minor_det_in, sticky |= minor_ovf_in; go to M1.
- M1:
  - minor_out = {a21,a23,a31,a33}.
  - At the edge: acc -= a12*minor_det_in; sticky |= minor_ovf_in; go to M2.
- M2:
  - minor_out = {a21,a22,a31,a32}.
  - At the edge: acc += a13*minor_det_in; sticky |= minor_ovf_in; go to FIN.
- FIN: at the edge, register outputs, then go to IDLE with busy<=0 and done<=1 for exactly one cycle.
  - range_ovf = (acc > 127) || (acc < -128).
  - overflow_flag <= range_ovf | sticky.
  - SAT=0: det <= acc[7:0]. SAT=1 and range_ovf: det <= +127 or -128 by sign. Otherwise det <= acc[7:0].
- Products: 8x8 signed gives 16 bits, sign-extended to ACC_W. All arithmetic is signed. Minor determinants are used as returned (already 8-bit truncated); the sticky flag records their loss.
- minor_out is driven only from the latched matrix, never from live matriz_3x3. It is 0 in IDLE and FIN.
- Latency: done is high in the 5th cycle after the accepting edge (4 edges in flight).
- Throughput: a new start is accepted in the done cycle, giving a 5-cycle issue interval.
- start while busy is ignored: no queueing, no effect on the current operation.
- Changing matriz_3x3 while busy has no effect.
- det and overflow_flag hold their last value until the next FIN; they are not cleared at start.
- rst_n asserted mid-operation: abort immediately to reset values; no done pulse.

Test Plan:
- Identity matrix, start pulse -> 2x2 model sees minors {1,0,0,1},{0,0,0,1},{0,1,0,0}; done 5 cycles later; det=1, overflow_flag=0; busy high 4 cycles.
- [[1,2,3],[4,5,6],[7,8,9]] -> det=0, overflow_flag=0.
- [[2,0,0],[0,3,0],[0,0,-4]] -> det=-24 (0xE8), overflow_flag=0.
- [[10,0,0],[0,10,0],[0,0,10]] with 2x2 model returning 100 -> acc=1000:
  - SAT=0: det=0xE8, overflow_flag=1.
  - SAT=1: det=127, overflow_flag=1.
- [[1,0,0],[0,100,-100],[0,100,100]] -> M11 overflows in the 2x2 unit (20000 truncated to 0x20=32, flag=1) -> det=32, overflow_flag=1 via sticky.
- Ignored start, reset abort and back-to-back:
  - start re-pulsed during M1 with a different matrix -> ignored; result matches the first matrix.
  - rst_n low during M2 -> all outputs 0, no done.
  - start in the done cycle -> second result 5 cycles later.

Source files
------------

// File: rtl/det3x3_seq_ctrl.sv
// 3x3 determinant sequencer: cofactor expansion along row 1 through a shared 2x2 determinant unit.
module det3x3_seq_ctrl #(
   parameter int unsigned ACC_W = 18,
   parameter bit          SAT   = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [71:0] matriz_3x3,
   output logic [31:0] minor_out,
   input  logic [7:0]  minor_det_in,
   input  logic        minor_ovf_in,
   output logic        busy,
   output logic        done,
   output logic [7:0]  det,
   output logic        overflow_flag
);

   localparam int unsigned EL_W   = 8;
   localparam int unsigned PROD_W = 16;
   localparam int unsigned MAT_W  = 72;
   localparam int unsigned MIN_W  = 32;

   localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(127);
   localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-128);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_M0   = 3'd1,
      ST_M1   = 3'd2,
      ST_M2   = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [MAT_W-1:0]         mat_q, mat_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     sticky_q, sticky_d;
   logic [MIN_W-1:0]         minor_q, minor_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [EL_W-1:0]          det_q, det_d;
   logic                     ovf_q, ovf_d;

   logic signed [EL_W-1:0]   coef;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic                     range_ovf;

   // Minor presented to the 2x2 unit for a given state (row 1 and column k removed).
   function automatic logic [MIN_W-1:0] minor_sel(input state_t st, input logic [MAT_W-1:0] m);
      logic [MIN_W-1:0] r;
      r = '0;
      case (st)
         ST_M0:   r = {m[39:32], m[31:24], m[15:8],  m[7:0]};
         ST_M1:   r = {m[47:40], m[31:24], m[23:16], m[7:0]};
         ST_M2:   r = {m[47:40], m[39:32], m[23:16], m[15:8]};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Row-1 coefficient times returned minor determinant, sign-extended to the accumulator.
   always_comb begin
      coef = '0;
      case (state_q)
         ST_M0:   coef = $signed(mat_q[71:64]);
         ST_M1:   coef = $signed(mat_q[63:56]);
         ST_M2:   coef = $signed(mat_q[55:48]);
         default: coef = '0;
      endcase
      prod      = PROD_W'(coef) * PROD_W'($signed(minor_det_in));
      prod_ext  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      range_ovf = (acc_q > POS_LIM) || (acc_q < NEG_LIM);
   end

   // Next-state and next-output logic; minor_out is registered from the next state.
   always_comb begin
      state_d  = state_q;
      mat_d    = mat_q;
      acc_d    = acc_q;
      sticky_d = sticky_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      det_d    = det_q;
      ovf_d    = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mat_d    = matriz_3x3;
               acc_d    = '0;
               sticky_d = 1'b0;
               busy_d   = 1'b1;
               state_d  = ST_M0;
            end
         end
         ST_M0: begin
            acc_d    = acc_q + prod_ext;
            sticky_d = sticky_q | minor_ovf_in;
            state_d  = ST_M1;
         end
         ST_M1: begin
            acc_d    = acc_q - prod_ext;
            sticky_d = sticky_q | minor_ovf_in;
            state_d  = ST_M2;
         end
         ST_M2: begin
            acc_d    = acc_q + prod_ext;
            sticky_d = sticky_q | minor_ovf_in;
            state_d  = ST_FIN;
         end
         ST_FIN: begin
            ovf_d = range_ovf | sticky_q;
            if (SAT && range_ovf) begin
               det_d = acc_q[ACC_W-1] ? 8'h80 : 8'h7F;
            end else begin
               det_d = acc_q[EL_W-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      minor_d = minor_sel(state_d, mat_d);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         mat_q    <= '0;
         acc_q    <= '0;
         sticky_q <= 1'b0;
         minor_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         det_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mat_q    <= mat_d;
         acc_q    <= acc_d;
         sticky_q <= sticky_d;
         minor_q  <= minor_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         det_q    <= det_d;
         ovf_q    <= ovf_d;
      end
   end

   assign minor_out     = minor_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign det           = det_q;
   assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_det3x3_seq_ctrl.sv
// Bench for det3x3_seq_ctrl: truncating and saturating instances, each with its own 2x2 determinant model.
module tb_det3x3_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [71:0] matriz;
   logic [31:0] minor0, minor1;
   logic [7:0]  mdet0, mdet1;
   logic        movf0, movf1;
   logic        busy0, busy1, done0, done1;
   logic [7:0]  det0, det1;
   logic        ovf0, ovf1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [8:0] prev0, prev1;

   always #5 clk = ~clk;

   det3x3_seq_ctrl #(.ACC_W(18), .SAT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .matriz_3x3(matriz),
      .minor_out(minor0), .minor_det_in(mdet0), .minor_ovf_in(movf0),
      .busy(busy0), .done(done0), .det(det0), .overflow_flag(ovf0));

   det3x3_seq_ctrl #(.ACC_W(18), .SAT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .matriz_3x3(matriz),
      .minor_out(minor1), .minor_det_in(mdet1), .minor_ovf_in(movf1),
      .busy(busy1), .done(done1), .det(det1), .overflow_flag(ovf1));

   // Combinational 2x2 determinant unit: {overflow, truncated 8-bit det}.
   function automatic logic [8:0] det2(input logic [31:0] mi);
      int p;
      p = int'($signed(mi[31:24])) * int'($signed(mi[7:0]))
        - int'($signed(mi[23:16])) * int'($signed(mi[15:8]));
      return {(p > 127 || p < -128), 8'(p)};
   endfunction

   assign {movf0, mdet0} = det2(minor0);
   assign {movf1, mdet1} = det2(minor1);

   function automatic logic [71:0] mk(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
      return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
   endfunction

   function automatic int elem(input logic [71:0] m, input int i);
      logic [7:0] e;
      e = m[71-8*i -: 8];
      return int'($signed(e));
   endfunction

   // Expected minor for cofactor k: rows 2-3 with column k removed.
   function automatic logic [31:0] exp_minor(input logic [71:0] m, input int k);
      int c0, c1;
      c0 = (k == 0) ? 1 : 0;
      c1 = (k == 2) ? 1 : 2;
      return {8'(elem(m, 3+c0)), 8'(elem(m, 3+c1)), 8'(elem(m, 6+c0)), 8'(elem(m, 6+c1))};
   endfunction

   // Reference: signed cofactor sum with minors truncated as the 2x2 unit returns them.
   function automatic logic [8:0] ref_det(input logic [71:0] m, input bit sat);
      int a[9];
      int acc, md, mt, c0, c1;
      bit sticky, rng;
      logic [7:0] b, d;
      for (int i = 0; i < 9; i++) a[i] = elem(m, i);
      acc = 0;
      sticky = 1'b0;
      for (int k = 0; k < 3; k++) begin
         c0 = (k == 0) ? 1 : 0;
         c1 = (k == 2) ? 1 : 2;
         md = a[3+c0] * a[6+c1] - a[3+c1] * a[6+c0];
         b  = 8'(md);
         mt = int'($signed(b));
         if (md > 127 || md < -128) sticky = 1'b1;
         acc += ((k == 1) ? -1 : 1) * a[k] * mt;
      end
      rng = (acc > 127) || (acc < -128);
      if (sat && rng) d = (acc < 0) ? 8'h80 : 8'h7F;
      else            d = 8'(acc);
      return {rng | sticky, d};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Run one operation starting at a negedge; returns at the negedge where done is seen.
   task automatic run_op(input logic [71:0] m, input logic [71:0] m_alt, input int glitch,
                         input logic [8:0] e0, input logic [8:0] e1, input string tag);
      int cyc;
      int busy_n;
      matriz = m;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      matriz = ~m;
      cyc    = 1;
      busy_n = 0;
      chk({tag, " det_held"}, 32'(det0), 32'(prev0[7:0]));
      chk({tag, " ovf_held"}, 32'(ovf1), 32'(prev1[8]));
      while (done0 !== 1'b1 && cyc < 20) begin
         if (busy0 === 1'b1) busy_n++;
         if (cyc >= 1 && cyc <= 3)
            chk($sformatf("%s minor%0d", tag, cyc-1), minor0, exp_minor(m, cyc-1));
         if (cyc == 4) chk({tag, " minor_fin"}, minor1, 32'h0);
         if (cyc == glitch) begin
            matriz = m_alt;
            start  = 1'b1;
         end else begin
            start  = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      chk({tag, " latency"}, 32'(cyc), 32'd5);
      chk({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
      chk({tag, " done_sat"}, 32'(done1), 32'd1);
      chk({tag, " busy_low"}, 32'(busy0), 32'd0);
      chk({tag, " det_trunc"}, 32'(det0), 32'(e0[7:0]));
      chk({tag, " ovf_trunc"}, 32'(ovf0), 32'(e0[8]));
      chk({tag, " det_sat"}, 32'(det1), 32'(e1[7:0]));
      chk({tag, " ovf_sat"}, 32'(ovf1), 32'(e1[8]));
      chk({tag, " minor_idle"}, minor0, 32'h0);
      prev0 = e0;
      prev1 = e1;
   endtask

   typedef struct {
      logic [71:0] mat;
      logic [71:0] alt;
      int          glitch;
      logic [8:0]  exp0;
      logic [8:0]  exp1;
   } vec_t;

   vec_t vecs[11];

   function automatic int rnd_el();
      if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 255)) - 128;
      return int'($urandom_range(0, 16)) - 8;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [71:0] ma, mb, mr;
      rst_n  = 1'b0;
      start  = 1'b0;
      matriz = '0;
      prev0  = '0;
      prev1  = '0;

      // {mat, alt, glitch cycle, {ovf,det} SAT=0, {ovf,det} SAT=1}
      vecs[0]  = '{mk(1,0,0, 0,1,0, 0,0,1),      '0, 0, 9'h001, 9'h001};
      vecs[1]  = '{mk(1,2,3, 4,5,6, 7,8,9),      '0, 0, 9'h000, 9'h000};
      vecs[2]  = '{mk(2,0,0, 0,3,0, 0,0,-4),     '0, 0, 9'h0E8, 9'h0E8};
      vecs[3]  = '{mk(10,0,0, 0,10,0, 0,0,10),   '0, 0, 9'h1E8, 9'h17F};
      vecs[4]  = '{mk(1,0,0, 0,100,-100, 0,100,100), '0, 0, 9'h120, 9'h120};
      vecs[5]  = '{mk(-10,0,0, 0,10,0, 0,0,10),  '0, 0, 9'h118, 9'h180};
      vecs[6]  = '{mk(127,0,0, 0,1,0, 0,0,1),    '0, 0, 9'h07F, 9'h07F};
      vecs[7]  = '{mk(-128,0,0, 0,1,0, 0,0,1),   '0, 0, 9'h080, 9'h080};
      vecs[8]  = '{mk(64,0,0, 0,2,0, 0,0,1),     '0, 0, 9'h180, 9'h17F};
      vecs[9]  = '{mk(1,0,0, 0,1,0, 0,0,1), mk(10,0,0, 0,10,0, 0,0,10), 2, 9'h001, 9'h001};
      vecs[10] = '{mk(0,1,0, 1,0,0, 0,0,1),      '0, 0, 9'h0FF, 9'h0FF};

      repeat (3) @(negedge clk);
      chk("rst busy",  32'(busy0), 32'd0);
      chk("rst done",  32'(done1), 32'd0);
      chk("rst det",   32'(det0),  32'd0);
      chk("rst ovf",   32'(ovf1),  32'd0);
      chk("rst minor", minor0,     32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         run_op(vecs[i].mat, vecs[i].alt, vecs[i].glitch, vecs[i].exp0, vecs[i].exp1,
                $sformatf("vec%0d", i));
      end

      // Reset asserted during M2: immediate abort, no done pulse.
      @(negedge clk);
      matriz = mk(1,2,3, 4,5,6, 7,8,10);
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort busy",  32'(busy0), 32'd0);
      chk("abort det",   32'(det0),  32'd0);
      chk("abort ovf",   32'(ovf0),  32'd0);
      chk("abort minor", minor1,     32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("abort no_done%0d", i), 32'(done0 | done1), 32'd0);
      end
      rst_n = 1'b1;
      prev0 = '0;
      prev1 = '0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("post_abort idle%0d", i), 32'(busy0 | done0), 32'd0);
      end

      // Back-to-back: second start issued in the done cycle of the first.
      ma = mk(0,1,0, 1,0,0, 0,0,1);
      mb = mk(2,0,0, 0,3,0, 0,0,-4);
      run_op(ma, '0, 0, 9'h0FF, 9'h0FF, "b2b_a");
      run_op(mb, '0, 0, 9'h0E8, 9'h0E8, "b2b_b");

      // Randomized matrices against the reference model, with random gaps.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 1) == 1) @(negedge clk);
         mr = mk(rnd_el(), rnd_el(), rnd_el(), rnd_el(), rnd_el(),
                 rnd_el(), rnd_el(), rnd_el(), rnd_el());
         run_op(mr, mk(rnd_el(), 1, 2, 3, 4, 5, 6, 7, 8),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                ref_det(mr, 1'b0), ref_det(mr, 1'b1), $sformatf("rnd%0d", n));
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
